// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Define REGRD_ARB_STREAM_EN to allow a new grant in the same cycle as the response handshake.
module regfile_read_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*5-1:0] req_addr,
   output logic [NREQ-1:0]   req_ready,
   output logic [4:0]        mux_select,
   input  logic [WIDTH-1:0]  mux_data,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [WIDTH-1:0]  rsp_data,
   input  logic              rsp_ready,
   output logic              busy
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] gnt;
   logic           found;
   logic           grant_en;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
      logic [IDW:0] r;
      int unsigned  j;
      r = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(p) + k) % NREQ;
         if (!r[IDW] && v[j]) r = {1'b1, IDW'(j)};
      end
      return r;
   endfunction

   always_comb begin
      {found, gnt} = rr_pick(req_valid, ptr);
`ifdef REGRD_ARB_STREAM_EN
      grant_en = rst_n && found && ((state == IDLE) || rsp_ready);
`else
      grant_en = rst_n && found && (state == IDLE);
`endif
   end

   always_comb begin
      req_ready  = '0;
      mux_select = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_en && (gnt == IDW'(i))) begin
            req_ready[i] = 1'b1;
            mux_select   = req_addr[5*i +: 5];
         end
      end
   end

   assign busy = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (grant_en) begin
         state     <= RESP;
         rsp_valid <= 1'b1;
         rsp_id    <= gnt;
         rsp_data  <= mux_data;
         ptr       <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
         // rsp_data deliberately keeps its stale value until the next grant
         state     <= IDLE;
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed-vector bench for regfile_read_arbiter (NREQ=4); follows REGRD_ARB_STREAM_EN if defined.
module tb_regfile_read_arbiter;

`ifdef REGRD_ARB_STREAM_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [19:0] req_addr;
   logic [3:0]  req_ready;
   logic [4:0]  mux_select;
   logic [31:0] mux_data;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_ready;
   logic        busy;

   logic [31:0] rf [32];
   int n_vec = 0;
   int n_err = 0;

   assign mux_data = rf[mux_select];

   always #5 clk = ~clk;

   regfile_read_arbiter #(.NREQ(4), .WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .mux_select(mux_select), .mux_data(mux_data),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gl[8];
      int gc[8];
      int ng;
      int g;
      bit got;

      for (int i = 0; i < 32; i++) rf[i] = {4{8'(i)}};
      rf[5] = 32'hDEADBEEF;

      // Reset state, with all requests asserted
      rst_n = 1'b0; req_valid = 4'b1111; req_addr = '0; rsp_ready = 1'b0;
      #2;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mux_select", mux_select, 0);
      @(posedge clk); #1;
      chk("rst_hold_valid", rsp_valid, 0);
      req_valid = 4'b0000;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single read: requester 1, address 5
      req_valid = 4'b0010; req_addr = 20'd5 << 5;
      @(negedge clk);
      chk("single_req_ready", req_ready, 4'b0010);
      chk("single_mux_select", mux_select, 5);
      chk("single_busy_idle", busy, 0);
      @(posedge clk); #1;
      chk("single_rsp_valid", rsp_valid, 1);
      chk("single_rsp_id", rsp_id, 1);
      chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("single_busy", busy, 1);

      // Backpressure for 5 cycles, handshake on the 6th
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_id", rsp_id, 1);
         chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
         @(posedge clk); #1;
      end
      req_valid = 4'b0000; rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_rsp_valid", rsp_valid, 1);
      @(posedge clk); #1;
      chk("hs_busy", busy, 0);
      chk("hs_rsp_valid_low", rsp_valid, 0);
      chk("hs_stale_data", rsp_data, 32'hDEADBEEF);
      rsp_ready = 1'b0;

      // Wrap: grant to 3 (ptr is 2), then 0 and 3 valid -> 0
      req_addr = {5'd11, 5'd10, 5'd9, 5'd8};
      req_valid = 4'b1000;
      @(negedge clk);
      chk("wrap_req_ready3", req_ready, 4'b1000);
      chk("wrap_mux_select3", mux_select, 11);
      @(posedge clk); #1;
      chk("wrap_rsp_id3", rsp_id, 3);
      chk("wrap_rsp_data3", rsp_data, 32'h0B0B0B0B);
      req_valid = 4'b1001; rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            got = 1;
            chk("wrap_req_ready0", req_ready, 4'b0001);
            chk("wrap_mux_select0", mux_select, 8);
         end
         @(posedge clk); #1;
      end
      if (!got) chk("wrap_grant_timeout", 0, 1);
      rsp_ready = 1'b0; req_valid = 4'b0000;
      chk("wrap_rsp_valid", rsp_valid, 1);
      chk("wrap_rsp_id0", rsp_id, 0);

      // Asynchronous reset while a response is held
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_data", rsp_data, 0);
      chk("mid_rst_rsp_id", rsp_id, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Fairness: all valid, consumer always ready, pointer back at 0
      req_valid = 4'b1111; rsp_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 24 && ng < 6; c++) begin
         @(negedge clk);
         got = 0;
         if (req_ready != 0) begin
            chk("fair_onehot", $countones(req_ready), 1);
            g = oh_idx(req_ready);
            gl[ng] = g; gc[ng] = c; ng++; got = 1;
         end
         @(posedge clk); #1;
         if (got) begin
            chk("fair_rsp_id", rsp_id, g);
            chk("fair_rsp_data", rsp_data, {4{8'(8 + g)}});
         end
      end
      chk("fair_count", ng, 6);
      for (int k = 0; k < 6 && k < ng; k++) chk("fair_order", gl[k], k % 4);
      for (int k = 1; k < 6 && k < ng; k++) chk("fair_gap", gc[k] - gc[k-1], GAP);

      // Two requesters, consumer always ready: response spacing
      req_valid = 4'b0101;
      ng = 0;
      for (int c = 0; c < 16 && ng < 4; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            gl[ng] = oh_idx(req_ready); gc[ng] = c; ng++;
         end
         @(posedge clk); #1;
      end
      chk("two_count", ng, 4);
      for (int k = 0; k < 4 && k < ng; k++) chk("two_order", gl[k], (k % 2 == 0) ? 2 : 0);
      for (int k = 1; k < 4 && k < ng; k++) chk("two_gap", gc[k] - gc[k-1], GAP);

      req_valid = 4'b0000;
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares a single register-file read port, built from the 32-to-1 word multiplexer, between several requesters (core decode, UART debug reader, and similar). Grants are round-robin. The block drives the mux select, captures the selected word into a response register, and returns it with the requester ID over a valid/ready handshake. It sits between the requesters and the register-file read mux.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: register word width.
- `IDW`, $clog2(NREQ): width of requester ID.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: bit i = requester i has a pending read.
- `req_addr` in NREQ*5: requester i register index at [5i+4:5i].
- `req_ready` out NREQ: one-hot grant, combinational; request i is accepted in a cycle where `req_valid[i] && req_ready[i]`.
- `mux_select` out 5: drives the shared 32-to-1 mux select, combinational.
- `mux_data` in WIDTH: shared mux output, sampled in the grant cycle.
- `rsp_valid` out 1: response register holds data.
- `rsp_id` out IDW: requester that owns the response.
- `rsp_data` out WIDTH: captured register word.
- `rsp_ready` in 1: consumer accepts the response.
- `busy` out 1: 1 whenever the state is RESP.

## Operation
- Two states:
  - IDLE: the response register is empty.
  - RESP: the response is held.
- Round-robin pointer `ptr` (IDW bits).
  - Grant target: the first i with `req_valid[i]`=1, searching from `ptr` upward, modulo NREQ.
- Grant allowed when state = IDLE and any `req_valid`=1. In that cycle:
  - `req_ready[g]`=1 and all other bits are 0.
  - `mux_select` = `req_addr[g]`.
  - On the edge: `rsp_data` <= `mux_data`, `rsp_id` <= g, `rsp_valid` <= 1, `ptr` <= (g+1) mod NREQ, state <= RESP.
- When no grant is issued: `req_ready`=0 and `mux_select`=5'd0.
- RESP:
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable until `rsp_ready`=1.
  - On the handshake edge, state <= IDLE and `rsp_valid` <= 0, unless a streaming grant occurs (see Configuration).
- `rsp_data` is not modified on the handshake; it keeps its stale value until the next grant.
- Index 0 is not special: the arbiter passes whatever the mux returns.
- `req_valid` may drop without being granted. No request is latched before it is granted.
- Requester-side rule: `req_addr[i]` must be stable while `req_valid[i]`=1.

## Timing
- Reset, asynchronous and immediate, including mid-RESP:
  - state = IDLE, `ptr` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `busy` = 0, `req_ready` = 0, `mux_select` = 0.
- Latency: grant in cycle N, then `rsp_valid`=1 from cycle N+1.
- Combinational path `req_valid`/`req_addr` -> `mux_select` -> mux -> `mux_data` -> `rsp_data` D-input must close in one cycle.
- No combinational path from `rsp_ready` to `req_ready` unless `REGRD_ARB_STREAM_EN` is defined.
- Throughput without the macro: at most one grant per 2 cycles.
- Pointer wrap: a grant to NREQ-1 sets `ptr` to 0.

## Configuration
- `REGRD_ARB_STREAM_EN` defined:
  - In RESP with `rsp_ready`=1, a grant may be issued in the same cycle.
  - The response register reloads and state stays RESP.
  - Throughput is one read per cycle.
  - `req_ready` then depends combinationally on `rsp_ready`.
- `REGRD_ARB_STREAM_EN` undefined:
  - No grant in RESP.
  - At least one IDLE cycle between consecutive responses.

## Test plan
- Single read, NREQ=4: only `req_valid[1]`, addr 5, mux returns 0xDEADBEEF.
  - Cycle 0: `req_ready`=4'b0010, `mux_select`=5.
  - Cycle 1: `rsp_valid`=1, `rsp_id`=1, `rsp_data`=0xDEADBEEF.
- Fairness: all four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,1.
- Backpressure: `rsp_ready`=0 for 5 cycles after a response → `rsp_*` unchanged, `req_ready`=0, `busy`=1 throughout. Handshake on cycle 6 → `busy`=0 the next cycle.
- Wrap: grant to 3, then only requesters 0 and 3 valid → next grant is 0.
- Reset mid-operation: `rst_n` low while `rsp_valid`=1 → `rsp_valid`, `rsp_data`, `rsp_id` read 0 before the next clock edge. After release the first grant goes to requester 0.
- Macro: two requesters valid, `rsp_ready`=1.
  - With `REGRD_ARB_STREAM_EN`: responses on consecutive cycles.
  - Without it: responses every other cycle.
